// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, register IDs, status codes and E-register bubble values.
package y86_pkg;
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RSP   = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      STAT_AOK = 2'd0,
      STAT_HLT = 2'd1,
      STAT_ADR = 2'd2,
      STAT_INS = 2'd3
   } stat_t;

   localparam logic [3:0] BUB_ICODE = I_NOP;
   localparam logic [3:0] BUB_IFUN  = 4'h0;
endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational reads, two synchronous writes (M port wins).
module y86_regfile
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   input  logic [3:0]  dst_e,
   input  logic [63:0] val_e,
   input  logic [3:0]  dst_m,
   input  logic [63:0] val_m
);
   logic [63:0] regs [15];

   assign val_a = (src_a == RNONE) ? 64'd0 : regs[src_a];
   assign val_b = (src_b == RNONE) ? 64'd0 : regs[src_b];

   // The M write is issued last so it overrides E when both target one register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
      end else begin
         if (dst_e != RNONE) regs[dst_e] <= val_e;
         if (dst_m != RNONE) regs[dst_m] <= val_m;
      end
   end
endmodule

// File: rtl/y86_decode.sv
// Y86-64 decode/write-back stage with E pipeline register.
// DECODE_FWD_EN selects full operand forwarding; otherwise d_data_hazard requests a stall.
module y86_decode
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_ifun,
   input  logic [3:0]  D_rA,
   input  logic [3:0]  D_rB,
   input  logic [63:0] D_valC,
   input  logic [63:0] D_valP,
   input  logic        D_hlt,
   input  logic        D_in_mem,
   input  logic        D_in_inst,
   input  logic        E_bubble,
   input  logic [3:0]  e_dstE,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic [3:0]  W_dstE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] e_valE,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   input  logic [63:0] W_valE,
   input  logic [63:0] W_valM,
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   output logic        d_data_hazard,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   output logic [1:0]  E_stat
);
   logic [3:0]  d_dstE, d_dstM;
   logic [63:0] rf_a, rf_b, d_valA, d_valB;
   stat_t       d_stat;

   y86_regfile u_rf (
      .clk(clk), .rst(rst),
      .src_a(d_srcA), .src_b(d_srcB), .val_a(rf_a), .val_b(rf_b),
      .dst_e(W_dstE), .val_e(W_valE), .dst_m(W_dstM), .val_m(W_valM)
   );

   always_comb begin
      d_srcA = RNONE;
      d_srcB = RNONE;
      d_dstE = RNONE;
      d_dstM = RNONE;
      case (D_icode)
         I_RRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
         I_IRMOVQ: d_dstE = D_rB;
         I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
         I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
         I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
         I_CALL, I_RET: begin
            d_srcA = (D_icode == I_RET) ? RSP : RNONE;
            d_srcB = RSP;
            d_dstE = RSP;
         end
         I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP; d_dstE = RSP; end
         I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = D_rA; end
         default: ;
      endcase
   end

   always_comb begin
      if (D_in_mem)       d_stat = STAT_ADR;
      else if (D_in_inst) d_stat = STAT_INS;
      else if (D_hlt)     d_stat = STAT_HLT;
      else                d_stat = STAT_AOK;
   end

`ifdef DECODE_FWD_EN
   // Youngest producer first; m_valM outranks M_valE for a load into the same register.
   always_comb begin
      d_valA = rf_a;
      if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
      else if (d_srcA != RNONE) begin
         if      (d_srcA == e_dstE) d_valA = e_valE;
         else if (d_srcA == M_dstM) d_valA = m_valM;
         else if (d_srcA == M_dstE) d_valA = M_valE;
         else if (d_srcA == W_dstM) d_valA = W_valM;
         else if (d_srcA == W_dstE) d_valA = W_valE;
      end
   end

   always_comb begin
      d_valB = rf_b;
      if (d_srcB != RNONE) begin
         if      (d_srcB == e_dstE) d_valB = e_valE;
         else if (d_srcB == M_dstM) d_valB = m_valM;
         else if (d_srcB == M_dstE) d_valB = M_valE;
         else if (d_srcB == W_dstM) d_valB = W_valM;
         else if (d_srcB == W_dstE) d_valB = W_valE;
      end
   end

   assign d_data_hazard = 1'b0;
`else
   function automatic logic pending(input logic [3:0] src);
      return (src != RNONE) &&
             (src == e_dstE || src == M_dstE || src == M_dstM ||
              src == W_dstE || src == W_dstM);
   endfunction

   assign d_valA        = (D_icode == I_CALL || D_icode == I_JXX) ? D_valP : rf_a;
   assign d_valB        = rf_b;
   assign d_data_hazard = pending(d_srcA) || pending(d_srcB);

   logic unused_fwd;
   assign unused_fwd = ^{e_valE, M_valE, m_valM};
`endif

   always_ff @(posedge clk) begin
      if (rst || E_bubble) begin
         E_icode <= BUB_ICODE;
         E_ifun  <= BUB_IFUN;
         E_dstE  <= RNONE;
         E_dstM  <= RNONE;
         E_srcA  <= RNONE;
         E_srcB  <= RNONE;
         E_valC  <= 64'd0;
         E_valA  <= 64'd0;
         E_valB  <= 64'd0;
         E_stat  <= STAT_AOK;
      end else begin
         E_icode <= D_icode;
         E_ifun  <= D_ifun;
         E_dstE  <= d_dstE;
         E_dstM  <= d_dstM;
         E_srcA  <= d_srcA;
         E_srcB  <= d_srcB;
         E_valC  <= D_valC;
         E_valA  <= d_valA;
         E_valB  <= d_valB;
         E_stat  <= d_stat;
      end
   end
endmodule

// File: tb/tb_y86_decode.sv
// Scoreboard bench for y86_decode: random + directed D-stage traffic against a behavioural model.
module tb_y86_decode;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic        D_hlt, D_in_mem, D_in_inst, E_bubble;
   logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic [3:0]  d_srcA, d_srcB;
   logic        d_data_hazard;
   logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [1:0]  E_stat;

   y86_decode dut (
      .clk(clk), .rst(rst),
      .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP),
      .D_hlt(D_hlt), .D_in_mem(D_in_mem), .D_in_inst(D_in_inst),
      .E_bubble(E_bubble),
      .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .d_data_hazard(d_data_hazard),
      .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .E_srcA(E_srcA), .E_srcB(E_srcB),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_stat(E_stat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  icode, ifun, dstE, dstM, srcA, srcB;
      logic [63:0] valC, valA, valB;
      logic [1:0]  stat;
   } e_t;

   e_t          exp_q[$];
   logic [63:0] rf_m [15];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Spec-level decode rules, written as instruction-class membership.
   function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'hB, 4'h9}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
      if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
      return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
   endfunction

   function automatic logic [63:0] m_read(input logic [3:0] src);
      logic [3:0]  dsts [5];
      logic [63:0] vals [5];
      dsts = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
      vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
      if (src == 4'hF) return 64'd0;
`ifdef DECODE_FWD_EN
      for (int i = 0; i < 5; i++) if (dsts[i] == src) return vals[i];
`endif
      return rf_m[src];
   endfunction

   function automatic logic m_hazard(input logic [3:0] sa, input logic [3:0] sb);
`ifdef DECODE_FWD_EN
      return 1'b0;
`else
      logic [3:0] dsts [5];
      dsts = '{e_dstE, M_dstE, M_dstM, W_dstE, W_dstM};
      for (int i = 0; i < 5; i++)
         if ((sa != 4'hF && sa == dsts[i]) || (sb != 4'hF && sb == dsts[i])) return 1'b1;
      return 1'b0;
`endif
   endfunction

   // Inputs are already driven; check combinational outputs, push E expectation, cross the edge.
   task automatic step();
      e_t e;
      logic [3:0] sa, sb;
      sa = m_srcA(D_icode, D_rA);
      sb = m_srcB(D_icode, D_rB);
      #1;
      check("d_srcA", {60'd0, d_srcA}, {60'd0, sa});
      check("d_srcB", {60'd0, d_srcB}, {60'd0, sb});
      check("d_data_hazard", {63'd0, d_data_hazard}, {63'd0, m_hazard(sa, sb)});
      if (rst || E_bubble) begin
         e = '{icode: 4'h1, ifun: 4'h0, dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF,
               valC: 64'd0, valA: 64'd0, valB: 64'd0, stat: 2'd0};
      end else begin
         e.icode = D_icode;
         e.ifun  = D_ifun;
         e.srcA  = sa;
         e.srcB  = sb;
         e.dstE  = m_dstE(D_icode, D_rB);
         e.dstM  = m_dstM(D_icode, D_rA);
         e.valC  = D_valC;
         e.valA  = (D_icode == 4'h8 || D_icode == 4'h7) ? D_valP : m_read(sa);
         e.valB  = m_read(sb);
         e.stat  = D_in_mem ? 2'd2 : D_in_inst ? 2'd3 : D_hlt ? 2'd1 : 2'd0;
      end
      exp_q.push_back(e);
      if (rst) begin
         for (int i = 0; i < 15; i++) rf_m[i] = 64'd0;
      end else begin
         if (W_dstE != 4'hF) rf_m[W_dstE] = W_valE;
         if (W_dstM != 4'hF) rf_m[W_dstM] = W_valM;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet();
      rst = 0; E_bubble = 0;
      D_icode = 4'h1; D_ifun = 0; D_rA = 4'hF; D_rB = 4'hF;
      D_valC = 0; D_valP = 0; D_hlt = 0; D_in_mem = 0; D_in_inst = 0;
      e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
   endtask

   task automatic randomize_inputs();
      rst       = ($urandom_range(0, 99) == 0);
      E_bubble  = ($urandom_range(0, 9) == 0);
      D_icode   = 4'($urandom_range(0, 15));
      D_ifun    = 4'($urandom);
      D_rA      = 4'($urandom);
      D_rB      = 4'($urandom);
      D_valC    = {$urandom, $urandom};
      D_valP    = {$urandom, $urandom};
      D_hlt     = ($urandom_range(0, 7) == 0);
      D_in_mem  = ($urandom_range(0, 7) == 0);
      D_in_inst = ($urandom_range(0, 7) == 0);
      e_dstE = 4'($urandom); M_dstE = 4'($urandom); M_dstM = 4'($urandom);
      W_dstE = 4'($urandom); W_dstM = 4'($urandom);
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
      W_valM = {$urandom, $urandom};
   endtask

   // Monitor: E register is valid every cycle; compare one expectation per edge.
   initial begin
      e_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("E_icode", {60'd0, E_icode}, {60'd0, e.icode});
            check("E_ifun",  {60'd0, E_ifun},  {60'd0, e.ifun});
            check("E_dstE",  {60'd0, E_dstE},  {60'd0, e.dstE});
            check("E_dstM",  {60'd0, E_dstM},  {60'd0, e.dstM});
            check("E_srcA",  {60'd0, E_srcA},  {60'd0, e.srcA});
            check("E_srcB",  {60'd0, E_srcB},  {60'd0, e.srcB});
            check("E_valC",  E_valC, e.valC);
            check("E_valA",  E_valA, e.valA);
            check("E_valB",  E_valB, e.valB);
            check("E_stat",  {62'd0, E_stat}, {62'd0, e.stat});
         end
      end
   end

   initial begin
      for (int i = 0; i < 15; i++) rf_m[i] = 64'hX;
      quiet();
      @(negedge clk);
      rst = 1; step();
      rst = 1; step();
      // Read %rax after reset.
      quiet(); D_icode = 4'h2; D_rA = 4'h0; D_rB = 4'h1; step();
      // Forward from execute beats memory.
      quiet(); D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h2;
      e_dstE = 4'h3; e_valE = 64'h55; M_dstE = 4'h3; M_valE = 64'h99; step();
      // popq %rsp write-back: M value must win.
      quiet(); W_dstE = 4'h4; W_valE = 64'h100; W_dstM = 4'h4; W_valM = 64'h200; step();
      quiet(); D_icode = 4'h2; D_rA = 4'h4; D_rB = 4'h1; step();
      // call takes valP.
      quiet(); D_icode = 4'h8; D_valP = 64'h3A; step();
      // Bubble over a valid mrmovq.
      quiet(); D_icode = 4'h5; D_rA = 4'h1; D_rB = 4'h7; E_bubble = 1; step();
      // Status priority.
      quiet(); D_icode = 4'h1; D_in_mem = 1; D_in_inst = 1; D_hlt = 1; step();
      // Hazard against W_dstM.
      quiet(); D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h5; W_dstM = 4'h3; W_valM = 64'h77; step();
      for (int n = 0; n < 2000; n++) begin
         randomize_inputs();
         step();
      end
      quiet(); step();
      repeat (2) @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
